// File: rtl/acc_req_responder.sv
// Accelerator-side endpoint of the CVA6 accelerator request/response interface.
// Queues core requests, dispatches them in order to the backend and returns results tagged by trans_id.
module acc_req_responder #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [31:0]              req_insn_i,
  input  logic [XLEN-1:0]          req_rs1_i,
  input  logic [XLEN-1:0]          req_rs2_i,
  input  logic [2:0]               req_frm_i,
  input  logic [TRANS_ID_BITS-1:0] req_trans_id_i,
  input  logic                     req_store_pending_i,
  input  logic                     req_cons_en_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [XLEN-1:0]          resp_result_o,
  output logic [TRANS_ID_BITS-1:0] resp_trans_id_o,
  output logic                     resp_error_o,
  output logic                     resp_fflags_valid_o,
  output logic [4:0]               resp_fflags_o,
  output logic                     store_pending_o,
  output logic                     load_complete_o,
  output logic                     store_complete_o,
  output logic                     exe_valid_o,
  input  logic                     exe_ready_i,
  output logic [31:0]              exe_insn_o,
  output logic [XLEN-1:0]          exe_rs1_o,
  output logic [XLEN-1:0]          exe_rs2_o,
  output logic [2:0]               exe_frm_o,
  input  logic                     res_valid_i,
  output logic                     res_ready_o,
  input  logic [XLEN-1:0]          res_data_i,
  input  logic                     res_error_i,
  input  logic                     res_fflags_valid_i,
  input  logic [4:0]               res_fflags_i,
  input  logic                     ld_done_i,
  input  logic                     st_done_i
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [6:0]  OPC_LOAD  = 7'b0000111;
  localparam logic [6:0]  OPC_STORE = 7'b0100111;

  typedef struct packed {
    logic [31:0]              insn;
    logic [XLEN-1:0]          rs1;
    logic [XLEN-1:0]          rs2;
    logic [2:0]               frm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } req_t;

  req_t                     req_mem [DEPTH];
  logic [PTR_W-1:0]         req_wptr, req_rptr;
  logic [CNT_W-1:0]         req_cnt;
  logic [TRANS_ID_BITS-1:0] id_mem [DEPTH];
  logic [PTR_W-1:0]         id_wptr, id_rptr;
  logic [CNT_W-1:0]         id_cnt;
  logic [CNT_W-1:0]         st_cnt;

  req_t req_in, head;
  logic req_full, req_empty, id_full, id_empty;
  logic req_push, exe_hs, res_hs;
  logic head_is_load, head_is_store, hold;
  logic st_inc, st_dec;

  assign req_in = '{insn: req_insn_i, rs1: req_rs1_i, rs2: req_rs2_i,
                    frm: req_frm_i, trans_id: req_trans_id_i};
  assign head   = req_mem[req_rptr];

  // Full flags come from registered counts so ready never depends on a same-cycle pop
  assign req_full  = (req_cnt == CNT_W'(DEPTH));
  assign req_empty = (req_cnt == '0);
  assign id_full   = (id_cnt == CNT_W'(DEPTH));
  assign id_empty  = (id_cnt == '0);

  assign head_is_load  = (head.insn[6:0] == OPC_LOAD);
  assign head_is_store = (head.insn[6:0] == OPC_STORE);
  // Memory ops wait behind outstanding core stores when consistency mode is on
  assign hold = (head_is_load | head_is_store) & req_cons_en_i & req_store_pending_i;

  assign req_ready_o = !req_full;
  assign req_push    = req_valid_i & req_ready_o;
  assign exe_valid_o = !req_empty & !hold & !id_full;
  assign exe_hs      = exe_valid_o & exe_ready_i;
  assign res_ready_o = (!resp_valid_o | resp_ready_i) & !id_empty;
  assign res_hs      = res_valid_i & res_ready_o;

  assign exe_insn_o = head.insn;
  assign exe_rs1_o  = head.rs1;
  assign exe_rs2_o  = head.rs2;
  assign exe_frm_o  = head.frm;

  assign st_inc          = exe_hs & head_is_store;
  assign st_dec          = st_done_i & (st_cnt != '0);
  assign store_pending_o = (st_cnt != '0);

  // Queue storage; contents are qualified by the counts, so no reset is needed
  always_ff @(posedge clk_i) begin
    if (req_push) req_mem[req_wptr] <= req_in;
    if (exe_hs)   id_mem[id_wptr]   <= head.trans_id;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      req_wptr <= '0;
      req_rptr <= '0;
      req_cnt  <= '0;
      id_wptr  <= '0;
      id_rptr  <= '0;
      id_cnt   <= '0;
    end else begin
      if (req_push) req_wptr <= req_wptr + PTR_W'(1);
      if (exe_hs)   req_rptr <= req_rptr + PTR_W'(1);
      req_cnt <= req_cnt + CNT_W'(req_push) - CNT_W'(exe_hs);
      if (exe_hs)   id_wptr <= id_wptr + PTR_W'(1);
      if (res_hs)   id_rptr <= id_rptr + PTR_W'(1);
      id_cnt <= id_cnt + CNT_W'(exe_hs) - CNT_W'(res_hs);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_cnt           <= '0;
      load_complete_o  <= 1'b0;
      store_complete_o <= 1'b0;
    end else begin
      if (st_inc && !st_dec)      st_cnt <= st_cnt + CNT_W'(1);
      else if (!st_inc && st_dec) st_cnt <= st_cnt - CNT_W'(1);
      load_complete_o  <= ld_done_i;
      store_complete_o <= st_done_i;
    end
  end

  // Single-entry response register; refills in the same cycle it is drained
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resp_valid_o        <= 1'b0;
      resp_result_o       <= '0;
      resp_trans_id_o     <= '0;
      resp_error_o        <= 1'b0;
      resp_fflags_valid_o <= 1'b0;
      resp_fflags_o       <= '0;
    end else if (res_hs) begin
      resp_valid_o        <= 1'b1;
      resp_result_o       <= res_data_i;
      resp_trans_id_o     <= id_mem[id_rptr];
      resp_error_o        <= res_error_i;
      resp_fflags_valid_o <= res_fflags_valid_i;
      resp_fflags_o       <= res_fflags_i;
    end else if (resp_ready_i) begin
      resp_valid_o <= 1'b0;
    end
  end

  a_st_done_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    st_done_i |-> (st_cnt != '0));
  a_res_without_id: assert property (@(posedge clk_i) disable iff (!rst_ni)
    res_valid_i |-> !id_empty);

endmodule

// File: tb/tb_acc_req_responder.sv
// Directed bench for acc_req_responder: a cycle table for back-to-back flow plus
// hand-written sequences for reset, hold, full, store tracking and backpressure.
module tb_acc_req_responder;

  localparam logic [6:0]  OPC_ALU   = 7'b0110011;
  localparam logic [6:0]  OPC_LOAD  = 7'b0000111;
  localparam logic [6:0]  OPC_STORE = 7'b0100111;
  localparam logic [63:0] RS1_BASE  = 64'hA5A5_0000_0000_0000;

  logic        clk_i, rst_ni;
  logic        req_valid_i, req_ready_o;
  logic [31:0] req_insn_i;
  logic [63:0] req_rs1_i, req_rs2_i;
  logic [2:0]  req_frm_i, req_trans_id_i;
  logic        req_store_pending_i, req_cons_en_i;
  logic        resp_valid_o, resp_ready_i;
  logic [63:0] resp_result_o;
  logic [2:0]  resp_trans_id_o;
  logic        resp_error_o, resp_fflags_valid_o;
  logic [4:0]  resp_fflags_o;
  logic        store_pending_o, load_complete_o, store_complete_o;
  logic        exe_valid_o, exe_ready_i;
  logic [31:0] exe_insn_o;
  logic [63:0] exe_rs1_o, exe_rs2_o;
  logic [2:0]  exe_frm_o;
  logic        res_valid_i, res_ready_o;
  logic [63:0] res_data_i;
  logic        res_error_i, res_fflags_valid_i;
  logic [4:0]  res_fflags_i;
  logic        ld_done_i, st_done_i;

  int n_checks = 0;
  int n_fail   = 0;

  acc_req_responder dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_insn_i(req_insn_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_frm_i(req_frm_i),
    .req_trans_id_i(req_trans_id_i), .req_store_pending_i(req_store_pending_i),
    .req_cons_en_i(req_cons_en_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_result_o(resp_result_o),
    .resp_trans_id_o(resp_trans_id_o), .resp_error_o(resp_error_o),
    .resp_fflags_valid_o(resp_fflags_valid_o), .resp_fflags_o(resp_fflags_o),
    .store_pending_o(store_pending_o), .load_complete_o(load_complete_o),
    .store_complete_o(store_complete_o),
    .exe_valid_o(exe_valid_o), .exe_ready_i(exe_ready_i), .exe_insn_o(exe_insn_o),
    .exe_rs1_o(exe_rs1_o), .exe_rs2_o(exe_rs2_o), .exe_frm_o(exe_frm_o),
    .res_valid_i(res_valid_i), .res_ready_o(res_ready_o), .res_data_i(res_data_i),
    .res_error_i(res_error_i), .res_fflags_valid_i(res_fflags_valid_i),
    .res_fflags_i(res_fflags_i), .ld_done_i(ld_done_i), .st_done_i(st_done_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic        rv;
    logic [2:0]  id;
    logic        er;
    logic        resv;
    logic [63:0] rdata;
    logic        rr;
    logic        e_req_ready;
    logic        e_exe_valid;
    logic        e_res_ready;
    logic        e_resp_valid;
    logic [2:0]  e_resp_id;
    logic [63:0] e_resp_data;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic rv, input logic [2:0] id, input logic er,
                              input logic resv, input logic [63:0] rdata, input logic rr,
                              input logic erq, input logic eev, input logic ers,
                              input logic erv, input logic [2:0] eid, input logic [63:0] edata);
    vec_t v;
    v.rv = rv; v.id = id; v.er = er; v.resv = resv; v.rdata = rdata; v.rr = rr;
    v.e_req_ready = erq; v.e_exe_valid = eev; v.e_res_ready = ers;
    v.e_resp_valid = erv; v.e_resp_id = eid; v.e_resp_data = edata;
    return v;
  endfunction

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_i = 1'b0; req_insn_i = '0; req_rs1_i = '0; req_rs2_i = '0;
    req_frm_i = '0; req_trans_id_i = '0; req_store_pending_i = 1'b0; req_cons_en_i = 1'b0;
    resp_ready_i = 1'b0; exe_ready_i = 1'b0; res_valid_i = 1'b0; res_data_i = '0;
    res_error_i = 1'b0; res_fflags_valid_i = 1'b0; res_fflags_i = '0;
    ld_done_i = 1'b0; st_done_i = 1'b0;
  endtask

  task automatic drive_req(input logic [6:0] opc, input logic [2:0] id);
    req_valid_i    = 1'b1;
    req_insn_i     = {25'd0, opc};
    req_rs1_i      = RS1_BASE | 64'(id);
    req_rs2_i      = ~(RS1_BASE | 64'(id));
    req_frm_i      = id;
    req_trans_id_i = id;
  endtask

  // One result accepted this cycle, then checks it is presented the following cycle
  task automatic drain_one(input logic [2:0] exp_id, input logic [63:0] data);
    res_valid_i = 1'b1;
    res_data_i  = data;
    #2;
    chk1("drain_res_ready", res_ready_o, 1'b1);
    next_cyc();
    res_valid_i = 1'b0;
    #2;
    chk1("drain_resp_valid", resp_valid_o, 1'b1);
    chkw("drain_resp_id", 64'(resp_trans_id_o), 64'(exp_id));
    chkw("drain_resp_data", resp_result_o, data);
  endtask

  initial begin
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    #2;
    chk1("rst_req_ready", req_ready_o, 1'b1);
    chk1("rst_exe_valid", exe_valid_o, 1'b0);
    chk1("rst_res_ready", res_ready_o, 1'b0);
    chk1("rst_resp_valid", resp_valid_o, 1'b0);
    chk1("rst_store_pending", store_pending_o, 1'b0);
    chk1("rst_load_complete", load_complete_o, 1'b0);
    chk1("rst_store_complete", store_complete_o, 1'b0);

    // Back-to-back IDs 1,2,3 with results following dispatch
    vecs[0] = mk(0, 3'd0, 0, 0, 64'h0,  0, 1, 0, 0, 0, 3'd0, 64'h0);
    vecs[1] = mk(1, 3'd1, 1, 0, 64'h0,  0, 1, 0, 0, 0, 3'd0, 64'h0);
    vecs[2] = mk(1, 3'd2, 1, 0, 64'h0,  0, 1, 1, 0, 0, 3'd0, 64'h0);
    vecs[3] = mk(1, 3'd3, 1, 1, 64'h11, 0, 1, 1, 1, 0, 3'd0, 64'h0);
    vecs[4] = mk(0, 3'd0, 1, 1, 64'h22, 1, 1, 1, 1, 1, 3'd1, 64'h11);
    vecs[5] = mk(0, 3'd0, 1, 1, 64'h33, 1, 1, 0, 1, 1, 3'd2, 64'h22);
    vecs[6] = mk(0, 3'd0, 1, 0, 64'h0,  1, 1, 0, 0, 1, 3'd3, 64'h33);
    vecs[7] = mk(0, 3'd0, 0, 0, 64'h0,  1, 1, 0, 0, 0, 3'd0, 64'h0);
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].rv) drive_req(OPC_ALU, vecs[i].id);
      else req_valid_i = 1'b0;
      exe_ready_i  = vecs[i].er;
      res_valid_i  = vecs[i].resv;
      res_data_i   = vecs[i].rdata;
      resp_ready_i = vecs[i].rr;
      #2;
      chk1("tbl_req_ready", req_ready_o, vecs[i].e_req_ready);
      chk1("tbl_exe_valid", exe_valid_o, vecs[i].e_exe_valid);
      chk1("tbl_res_ready", res_ready_o, vecs[i].e_res_ready);
      chk1("tbl_resp_valid", resp_valid_o, vecs[i].e_resp_valid);
      if (vecs[i].e_resp_valid) begin
        chkw("tbl_resp_id", 64'(resp_trans_id_o), 64'(vecs[i].e_resp_id));
        chkw("tbl_resp_data", resp_result_o, vecs[i].e_resp_data);
      end
      next_cyc();
    end

    // Full request queue, then ID queue full blocking dispatch
    idle_inputs();
    resp_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_req(OPC_ALU, 3'(i));
      #2;
      chk1("full_accept_ready", req_ready_o, 1'b1);
      next_cyc();
    end
    drive_req(OPC_ALU, 3'd4);
    #2;
    chk1("full_ready_low", req_ready_o, 1'b0);
    chk1("full_exe_valid", exe_valid_o, 1'b1);
    next_cyc();
    exe_ready_i = 1'b1;
    #2;
    chk1("full_ready_during_pop", req_ready_o, 1'b0);
    chkw("full_head_insn", 64'(exe_insn_o), 64'({25'd0, OPC_ALU}));
    next_cyc();
    #2;
    chk1("full_ready_after_pop", req_ready_o, 1'b1);
    next_cyc();
    req_valid_i = 1'b0;
    #2;
    chk1("idq_fill_exe_valid", exe_valid_o, 1'b1);
    next_cyc();
    #2;
    chk1("idq_fill_exe_valid", exe_valid_o, 1'b1);
    next_cyc();
    #2;
    chk1("idq_full_block", exe_valid_o, 1'b0);
    next_cyc();
    for (int k = 0; k < 5; k++) drain_one(3'(k), 64'hA0 + 64'(k));
    exe_ready_i = 1'b0;
    next_cyc();
    next_cyc();

    // Hold of a load behind pending core stores
    idle_inputs();
    resp_ready_i = 1'b1;
    exe_ready_i = 1'b1;
    req_cons_en_i = 1'b1;
    req_store_pending_i = 1'b1;
    drive_req(OPC_ALU, 3'd4);
    next_cyc();
    drive_req(OPC_LOAD, 3'd5);
    #2;
    chk1("hold_alu_passes", exe_valid_o, 1'b1);
    next_cyc();
    req_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk1("hold_blocked", exe_valid_o, 1'b0);
      next_cyc();
    end
    req_store_pending_i = 1'b0;
    #2;
    chk1("hold_released", exe_valid_o, 1'b1);
    chkw("hold_exe_insn", 64'(exe_insn_o), 64'({25'd0, OPC_LOAD}));
    chkw("hold_exe_rs1", exe_rs1_o, RS1_BASE | 64'd5);
    next_cyc();
    ld_done_i = 1'b1;
    #2;
    chk1("ld_pulse_pre", load_complete_o, 1'b0);
    chk1("hold_queue_empty", exe_valid_o, 1'b0);
    next_cyc();
    ld_done_i = 1'b0;
    #2;
    chk1("ld_pulse", load_complete_o, 1'b1);
    next_cyc();
    #2;
    chk1("ld_pulse_end", load_complete_o, 1'b0);
    req_cons_en_i = 1'b0;
    drain_one(3'd4, 64'h44);
    drain_one(3'd5, 64'h55);
    next_cyc();

    // Store counter: two stores, third store coincident with st_done
    idle_inputs();
    resp_ready_i = 1'b1;
    exe_ready_i = 1'b1;
    drive_req(OPC_STORE, 3'd1);
    #2;
    chk1("st_pending_init", store_pending_o, 1'b0);
    next_cyc();
    drive_req(OPC_STORE, 3'd2);
    #2;
    chk1("st_exe_valid", exe_valid_o, 1'b1);
    next_cyc();
    drive_req(OPC_STORE, 3'd3);
    #2;
    chk1("st_pending_cnt1", store_pending_o, 1'b1);
    next_cyc();
    req_valid_i = 1'b0;
    st_done_i = 1'b1;
    #2;
    chk1("st_third_dispatch", exe_valid_o, 1'b1);
    chk1("st_pending_cnt2", store_pending_o, 1'b1);
    next_cyc();
    st_done_i = 1'b0;
    #2;
    chk1("st_complete_pulse", store_complete_o, 1'b1);
    chk1("st_pending_coincident", store_pending_o, 1'b1);
    next_cyc();
    st_done_i = 1'b1;
    #2;
    chk1("st_complete_low", store_complete_o, 1'b0);
    chk1("st_pending_before_done", store_pending_o, 1'b1);
    next_cyc();
    #2;
    chk1("st_pending_one_left", store_pending_o, 1'b1);
    chk1("st_complete_2", store_complete_o, 1'b1);
    next_cyc();
    st_done_i = 1'b0;
    #2;
    chk1("st_pending_clear", store_pending_o, 1'b0);
    chk1("st_complete_3", store_complete_o, 1'b1);
    next_cyc();
    #2;
    chk1("st_complete_end", store_complete_o, 1'b0);
    for (int k = 1; k <= 3; k++) drain_one(3'(k), 64'h5000 + 64'(k));
    next_cyc();

    // Response backpressure with an error result
    idle_inputs();
    exe_ready_i = 1'b1;
    drive_req(OPC_ALU, 3'd6);
    next_cyc();
    drive_req(OPC_ALU, 3'd7);
    next_cyc();
    req_valid_i = 1'b0;
    next_cyc();
    exe_ready_i = 1'b0;
    res_valid_i = 1'b1;
    res_data_i = 64'hDEAD;
    res_error_i = 1'b1;
    res_fflags_valid_i = 1'b1;
    res_fflags_i = 5'h15;
    #2;
    chk1("bp_first_accept", res_ready_o, 1'b1);
    next_cyc();
    res_data_i = 64'hBEEF;
    res_error_i = 1'b0;
    res_fflags_valid_i = 1'b0;
    res_fflags_i = 5'h0;
    for (int i = 0; i < 3; i++) begin
      #2;
      chk1("bp_res_ready_low", res_ready_o, 1'b0);
      chk1("bp_resp_valid", resp_valid_o, 1'b1);
      chkw("bp_resp_id", 64'(resp_trans_id_o), 64'd6);
      chkw("bp_resp_data", resp_result_o, 64'hDEAD);
      chk1("bp_resp_error", resp_error_o, 1'b1);
      chk1("bp_fflags_valid", resp_fflags_valid_o, 1'b1);
      chkw("bp_fflags", 64'(resp_fflags_o), 64'h15);
      next_cyc();
    end
    resp_ready_i = 1'b1;
    #2;
    chk1("bp_release_res_ready", res_ready_o, 1'b1);
    chkw("bp_release_data", resp_result_o, 64'hDEAD);
    next_cyc();
    res_valid_i = 1'b0;
    #2;
    chk1("bp_refill_valid", resp_valid_o, 1'b1);
    chkw("bp_refill_id", 64'(resp_trans_id_o), 64'd7);
    chkw("bp_refill_data", resp_result_o, 64'hBEEF);
    chk1("bp_refill_error", resp_error_o, 1'b0);
    next_cyc();
    #2;
    chk1("bp_single_resp", resp_valid_o, 1'b0);
    next_cyc();

    // Reset in the middle of operation
    idle_inputs();
    exe_ready_i = 1'b1;
    drive_req(OPC_STORE, 3'd1);
    next_cyc();
    drive_req(OPC_STORE, 3'd2);
    next_cyc();
    drive_req(OPC_ALU, 3'd3);
    next_cyc();
    exe_ready_i = 1'b0;
    drive_req(OPC_ALU, 3'd4);
    next_cyc();
    drive_req(OPC_ALU, 3'd5);
    next_cyc();
    req_valid_i = 1'b0;
    #2;
    chk1("mid_store_pending", store_pending_o, 1'b1);
    chk1("mid_exe_valid", exe_valid_o, 1'b1);
    rst_ni = 1'b0;
    next_cyc();
    rst_ni = 1'b1;
    exe_ready_i = 1'b1;
    #2;
    chk1("mid_rst_req_ready", req_ready_o, 1'b1);
    chk1("mid_rst_exe_valid", exe_valid_o, 1'b0);
    chk1("mid_rst_store_pending", store_pending_o, 1'b0);
    chk1("mid_rst_resp_valid", resp_valid_o, 1'b0);
    chk1("mid_rst_res_ready", res_ready_o, 1'b0);
    next_cyc();
    #2;
    chk1("mid_rst_exe_stays_low", exe_valid_o, 1'b0);
    next_cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
